// File: rtl/gemm_dl_pkg.sv
// Shared definitions for the gemm deadlock reporter: FSM states, report tags and widths.
package gemm_dl_pkg;

  typedef enum logic [1:0] {
    WATCH,
    CONFIRM,
    REPORT,
    HOLD
  } dl_state_t;

  // Trailing records emitted once every INST record has gone out.
  typedef enum logic [1:0] {
    REC_TS_LO,
    REC_TS_HI,
    REC_END
  } dl_rec_t;

  localparam logic [3:0] TAG_INST  = 4'h1;
  localparam logic [3:0] TAG_TS_LO = 4'h2;
  localparam logic [3:0] TAG_TS_HI = 4'h3;
  localparam logic [3:0] TAG_END   = 4'hF;
  localparam int         TS_W      = 24;

endpackage

// File: rtl/gemm_dl_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit of vec, plus an any-bit-set flag.
module gemm_dl_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !any) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gemm_hls_deadlock_reporter.sv
// Qualifies monitor block flags with a persistence threshold and streams a deadlock report.
// Optional GEMM_DL_TIMESTAMP_EN adds a 24-bit cycle stamp (TS_LO/TS_HI records) before END.
module gemm_hls_deadlock_reporter
  import gemm_dl_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [15:0]        rpt_data,
  output logic               deadlock,
  output logic [NUM_MON-1:0] dl_mask
);

  localparam int CNT_W = $clog2(THRESH) + 1;
  localparam int IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;

`ifdef GEMM_DL_TIMESTAMP_EN
  localparam dl_rec_t TAIL_START = REC_TS_LO;
`else
  localparam dl_rec_t TAIL_START = REC_END;
`endif

  dl_state_t          state, state_n;
  dl_rec_t            tail, tail_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_MON-1:0] mask, mask_n;
  logic [NUM_MON-1:0] work, work_n;
  logic [NUM_MON-1:0] dl_mask_n;
  logic [7:0]         inst_cnt, inst_cnt_n;
  logic               deadlock_n;
  logic [IDX_W-1:0]   low_idx;
  logic               low_any;
  logic               blocked;
  logic               xfer;
  logic [TS_W-1:0]    ts_cap;

  assign blocked   = run & (|mon_block);
  assign rpt_valid = (state == REPORT);
  assign xfer      = rpt_valid & rpt_ready;

  gemm_dl_prio_enc #(
    .N     (NUM_MON),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec (work),
    .idx (low_idx),
    .any (low_any)
  );

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state    <= WATCH;
      tail     <= REC_END;
      cnt      <= '0;
      mask     <= '0;
      work     <= '0;
      inst_cnt <= '0;
      deadlock <= 1'b0;
      dl_mask  <= '0;
    end else begin
      state    <= state_n;
      tail     <= tail_n;
      cnt      <= cnt_n;
      mask     <= mask_n;
      work     <= work_n;
      inst_cnt <= inst_cnt_n;
      deadlock <= deadlock_n;
      dl_mask  <= dl_mask_n;
    end
  end

  always_comb begin
    state_n    = state;
    tail_n     = tail;
    cnt_n      = cnt;
    mask_n     = mask;
    work_n     = work;
    inst_cnt_n = inst_cnt;
    deadlock_n = deadlock;
    dl_mask_n  = dl_mask;
    case (state)
      WATCH: begin
        if (blocked) begin
          state_n = CONFIRM;
          cnt_n   = CNT_W'(1);
          mask_n  = mon_block;
        end else begin
          cnt_n  = '0;
          mask_n = '0;
        end
      end
      CONFIRM: begin
        if (!blocked) begin
          state_n = WATCH;
          cnt_n   = '0;
          mask_n  = '0;
        end else if (cnt == CNT_W'(THRESH - 1)) begin
          state_n    = REPORT;
          deadlock_n = 1'b1;
          mask_n     = mask | mon_block;
          dl_mask_n  = mask | mon_block;
          work_n     = mask | mon_block;
          inst_cnt_n = '0;
          tail_n     = TAIL_START;
        end else begin
          mask_n = mask | mon_block;
          cnt_n  = cnt + CNT_W'(1);
        end
      end
      REPORT: begin
        if (xfer) begin
          if (low_any) begin
            // x & (x-1) drops exactly the lowest set bit, i.e. the one just reported
            work_n     = work & (work - NUM_MON'(1));
            inst_cnt_n = inst_cnt + 8'd1;
          end else begin
            case (tail)
              REC_TS_LO: tail_n = REC_TS_HI;
              REC_TS_HI: tail_n = REC_END;
              default:   state_n = HOLD;
            endcase
          end
        end
      end
      HOLD: begin
      end
      default: state_n = WATCH;
    endcase
  end

  always_comb begin
    rpt_data = '0;
    if (state == REPORT) begin
      if (low_any) begin
        rpt_data = {TAG_INST, 12'(low_idx)};
      end else begin
        case (tail)
          REC_TS_LO: rpt_data = {TAG_TS_LO, ts_cap[11:0]};
          REC_TS_HI: rpt_data = {TAG_TS_HI, ts_cap[23:12]};
          default:   rpt_data = {TAG_END, 12'(inst_cnt)};
        endcase
      end
    end
  end

`ifdef GEMM_DL_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  // Capture the value ts will hold in the cycle deadlock becomes visible.
  always_ff @(posedge clock) begin
    if (reset || clear)                            ts_cap <= '0;
    else if (state == CONFIRM && state_n == REPORT) ts_cap <= ts + TS_W'(1);
  end
`else
  assign ts_cap = '0;
`endif

endmodule

// File: tb/tb_gemm_hls_deadlock_reporter.sv
// Self-checking bench for gemm_hls_deadlock_reporter: randomized blocking patterns vs a record-list model.
module tb_gemm_hls_deadlock_reporter;

  localparam int NUM_MON = 4;
  localparam int THRESH  = 16;

  logic               clock;
  logic               reset;
  logic               run;
  logic [NUM_MON-1:0] mon_block;
  logic               clear;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [15:0]        rpt_data;
  logic               deadlock;
  logic [NUM_MON-1:0] dl_mask;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [15:0]        exp_q[$];
  logic [15:0]        got_q[$];
  logic [NUM_MON-1:0] pats[THRESH];

  gemm_hls_deadlock_reporter #(
    .NUM_MON (NUM_MON),
    .THRESH  (THRESH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .mon_block (mon_block),
    .clear     (clear),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_data  (rpt_data),
    .deadlock  (deadlock),
    .dl_mask   (dl_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycles since reset release, the reference for the timestamp records.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Reference record list: one INST per blocked index ascending, optional stamp, END with count.
  function automatic void build_exp(input logic [NUM_MON-1:0] m, input int ts);
    int n;
    logic [23:0] t;
    n = 0;
    t = 24'(ts);
    exp_q.delete();
    for (int unsigned i = 0; i < NUM_MON; i++)
      if (m[i]) begin
        exp_q.push_back({4'h1, 12'(i)});
        n++;
      end
`ifdef GEMM_DL_TIMESTAMP_EN
    exp_q.push_back({4'h2, t[11:0]});
    exp_q.push_back({4'h3, t[23:12]});
`else
    if (t === 24'hxxxxxx) n = 0;
`endif
    exp_q.push_back({4'hF, 12'(n)});
  endfunction

  task automatic do_deadlock_scenario(input string name, input int stall, input bit rand_ready);
    logic [NUM_MON-1:0] exp_mask;
    logic [15:0]        prev_data;
    int                 c0, wait_n;
    bit                 early, done, prev_stalled;
    exp_mask = '0;
    early    = 1'b0;
    c0       = 0;
    for (int i = 0; i < THRESH; i++) exp_mask |= pats[i];
    for (int i = 0; i < THRESH; i++) begin
      @(negedge clock);
      if (i == 0) c0 = cyc;
      if (deadlock !== 1'b0 || rpt_valid !== 1'b0) early = 1'b1;
      clear     = 1'b0;
      run       = 1'b1;
      mon_block = pats[i];
    end
    checks++;
    if (early) $display("FAIL %s early_detect: deadlock/rpt_valid=1 before %0d blocked cycles, required 0", name, THRESH);
    else passes++;
    @(negedge clock);
    checks++;
    if (deadlock !== 1'b1 || rpt_valid !== 1'b1)
      $display("FAIL %s confirm: deadlock=%b rpt_valid=%b, required 1/1", name, deadlock, rpt_valid);
    else passes++;
    checks++;
    if (dl_mask !== exp_mask) $display("FAIL %s dl_mask: got %b, required %b", name, dl_mask, exp_mask);
    else passes++;

    build_exp(exp_mask, c0 + THRESH);
    got_q.delete();
    done = 1'b0; prev_stalled = 1'b0; wait_n = 0; prev_data = '0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (prev_stalled) begin
        checks++;
        if (rpt_valid !== 1'b1 || rpt_data !== prev_data)
          $display("FAIL %s stall_stable: valid=%b data=%h, required 1 %h", name, rpt_valid, rpt_data, prev_data);
        else passes++;
      end
      if (rpt_valid === 1'b1) begin
        rpt_ready    = rand_ready ? 1'($urandom_range(0, 1)) : (wait_n >= stall);
        prev_data    = rpt_data;
        prev_stalled = !rpt_ready;
        if (rpt_ready) begin
          got_q.push_back(rpt_data);
          wait_n = 0;
          if (rpt_data[15:12] == 4'hF) done = 1'b1;
        end else wait_n++;
      end else begin
        rpt_ready    = 1'($urandom_range(0, 1));
        prev_stalled = 1'b0;
      end
      run       = 1'($urandom_range(0, 1));
      mon_block = NUM_MON'($urandom);
      @(negedge clock);
    end
    checks++;
    if (!done) $display("FAIL %s end_timeout: no END record within 400 cycles, got %0d records", name, got_q.size());
    else passes++;
    checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s record_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    else passes++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) $display("FAIL %s record[%0d]: got %h, required %h", name, k, got_q[k], exp_q[k]);
      else passes++;
    end
    checks++;
    if (rpt_valid !== 1'b0 || deadlock !== 1'b1 || dl_mask !== exp_mask)
      $display("FAIL %s hold_entry: valid=%b deadlock=%b mask=%b, required 0 1 %b", name, rpt_valid, deadlock, dl_mask, exp_mask);
    else passes++;

    early = 1'b0;
    for (int i = 0; i < THRESH + 4; i++) begin
      run       = 1'b1;
      mon_block = NUM_MON'($urandom_range(1, 15));
      @(negedge clock);
      if (rpt_valid !== 1'b0 || deadlock !== 1'b1 || dl_mask !== exp_mask) early = 1'b1;
    end
    checks++;
    if (early) $display("FAIL %s hold_sticky: valid=%b deadlock=%b mask=%b, required 0 1 %b", name, rpt_valid, deadlock, dl_mask, exp_mask);
    else passes++;

    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0; run = 1'b0; mon_block = '0;
    checks++;
    if (deadlock !== 1'b0 || dl_mask !== '0 || rpt_valid !== 1'b0)
      $display("FAIL %s clear: deadlock=%b mask=%b valid=%b, required 0 0000 0", name, deadlock, dl_mask, rpt_valid);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; mon_block = '1; clear = 1'b0; rpt_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (rpt_valid !== 1'b0 || deadlock !== 1'b0 || dl_mask !== '0 || rpt_data !== '0)
      $display("FAIL reset_state: valid=%b deadlock=%b mask=%b data=%h, required all 0", rpt_valid, deadlock, dl_mask, rpt_data);
    else passes++;
    reset = 1'b0; run = 1'b0; mon_block = '0;
    @(negedge clock);
    checks++;
    if (rpt_valid !== 1'b0 || deadlock !== 1'b0)
      $display("FAIL reset_release: valid=%b deadlock=%b, required 0 0", rpt_valid, deadlock);
    else passes++;
  endtask

  task automatic test_single_block();
    for (int i = 0; i < THRESH; i++) pats[i] = 4'b0100;
    do_deadlock_scenario("single_block", 0, 1'b0);
  endtask

  task automatic test_transient();
    bit bad;
    int len;
    bad = 1'b0;
    for (int it = 0; it < 7; it++) begin
      len = (it == 0) ? THRESH - 1 : $urandom_range(1, THRESH - 1);
      for (int i = 0; i < len; i++) begin
        run       = 1'b1;
        mon_block = (it == 0) ? 4'b0010 : NUM_MON'($urandom_range(1, 15));
        @(negedge clock);
        if (rpt_valid !== 1'b0 || deadlock !== 1'b0) bad = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin run = 1'b1; mon_block = '0; end
      else begin run = 1'b0; mon_block = NUM_MON'($urandom_range(1, 15)); end
      @(negedge clock);
      if (rpt_valid !== 1'b0 || deadlock !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL transient: report raised for a run shorter than %0d cycles, required none", THRESH);
    else passes++;
    bad = 1'b0;
    run = 1'b0;
    for (int i = 0; i < THRESH + 4; i++) begin
      mon_block = NUM_MON'($urandom_range(1, 15));
      @(negedge clock);
      if (rpt_valid !== 1'b0 || deadlock !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL run_low: report raised while run=0, required none");
    else passes++;
    mon_block = '0;
  endtask

  task automatic test_alternating();
    for (int i = 0; i < THRESH; i++) pats[i] = (i % 2 == 0) ? 4'b0001 : 4'b1000;
    do_deadlock_scenario("alternating", 0, 1'b0);
  endtask

  task automatic test_random_deadlocks();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < THRESH; i++) pats[i] = NUM_MON'($urandom_range(1, 15));
      do_deadlock_scenario("random", 0, 1'b1);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < THRESH; i++) pats[i] = NUM_MON'($urandom_range(1, 15));
    pats[3] = 4'b1111;
    do_deadlock_scenario("stall5", 5, 1'b0);
  endtask

  task automatic test_clear_mid_report();
    rpt_ready = 1'b0;
    for (int i = 0; i < THRESH; i++) begin
      run = 1'b1; mon_block = 4'b0110;
      @(negedge clock);
    end
    checks++;
    if (rpt_valid !== 1'b1 || rpt_data !== 16'h1001)
      $display("FAIL clear_mid first_inst: valid=%b data=%h, required 1 1001", rpt_valid, rpt_data);
    else passes++;
    rpt_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (rpt_valid !== 1'b1 || rpt_data !== 16'h1002)
      $display("FAIL clear_mid second_inst: valid=%b data=%h, required 1 1002", rpt_valid, rpt_data);
    else passes++;
    clear = 1'b1; rpt_ready = 1'b0;
    @(negedge clock);
    clear = 1'b0; run = 1'b0; mon_block = '0;
    checks++;
    if (rpt_valid !== 1'b0 || deadlock !== 1'b0 || dl_mask !== '0)
      $display("FAIL clear_mid abandon: valid=%b deadlock=%b mask=%b, required 0 0 0000", rpt_valid, deadlock, dl_mask);
    else passes++;
    for (int i = 0; i < THRESH; i++) pats[i] = NUM_MON'($urandom_range(1, 15));
    do_deadlock_scenario("rereport", 0, 1'b1);
  endtask

  task automatic test_clear_vs_block();
    for (int i = 0; i < 5; i++) begin
      run = 1'b1; mon_block = 4'b1000;
      @(negedge clock);
    end
    // clear coincides with a blocked cycle carrying bit 0, which must not be counted or masked
    clear = 1'b1; mon_block = 4'b0001;
    for (int i = 0; i < THRESH; i++) pats[i] = 4'b1000;
    do_deadlock_scenario("clear_vs_block", 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_transient();
    test_alternating();
    test_random_deadlocks();
    test_stall();
    test_clear_mid_report();
    test_clear_vs_block();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, %0d/%0d checks passed so far", passes, checks);
    $fatal(1);
  end

endmodule
